apb_mem_completer_v2: RTL and testbench

Parametrised successor to the team's APB5 memory completer: word-organised RAM behind an APB5 completer interface.
- Data width, depth, secure-region size and wait-state count are generic.
- Adds TrustZone-style protection (secure masters reach everything), an APB5 read-strobe check, and a deterministic wait-state counter.
- Sits on an APB segment behind the interconnect as a scratch/config memory and as the DUT for the APB UVM environment.

---
 rtl/apb_mem_completer_v2.sv | 191 +++++++++++++++++++
 tb/tb_apb_mem_completer_v2.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_completer_v2.sv
// apb_mem_completer_v2
//   Word-organised RAM behind an APB5 completer interface. It checks
//   alignment, address range and secure-region access (pprot[1]=1 means
//   non-secure), and rejects reads that carry a non-zero pstrb. Each
//   error-free transfer stalls for a fixed WAIT_CYCLES number of cycles.
//
//   Optional feature macro: APB_MEM_INIT_EN. When it is defined, reset loads
//   word i with the value i, and the memory is built from flops. When it is
//   undefined, the memory has no reset and can be inferred as RAM.
//
// Ports:
//   pclk, preset_n      clock and asynchronous active-low reset
//   psel, penable       APB select and access-phase indicator
//   pwrite, paddr       transfer direction and byte address
//   pwdata, pstrb       write data and byte strobes
//   pprot               protection; bit 1 set means a non-secure master
//   prdata              read data, valid while pready=1
//   pready, pslverr     completion and error, both registered
module apb_mem_completer_v2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int MEM_DEPTH    = 256,
   parameter int SECURE_WORDS = 128,
   parameter int WAIT_CYCLES  = 0
) (
   input  logic                    pclk,
   input  logic                    preset_n,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [2:0]              pprot,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int AL    = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DONE = 2'd2} state_t;

   state_t                  state_reg;
   logic [3:0]              cnt_reg;
   logic [IDX_W-1:0]        idx_reg;
   logic                    write_reg;
   logic                    err_reg;
   logic [DATA_WIDTH-1:0]   wdata_reg;
   logic [BYTES-1:0]        strb_reg;

   logic                    setup;
   logic                    access;
   logic [ADDR_WIDTH-1:0]   word_idx;
   logic                    align_err;
   logic                    bus_err;
   logic [IDX_W-1:0]        rd_idx;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic                    mem_we;
   logic                    unused_ok;

   assign setup    = psel & ~penable;
   assign access   = psel & penable;
   assign word_idx = paddr >> AL;

   generate
      if (AL > 0) begin : g_align
         assign align_err = |paddr[AL-1:0];
      end else begin : g_no_align
         assign align_err = 1'b0;
      end
   endgenerate

   // The error is decoded from the setup-phase bus values and registered
   // together with them, so the result matches the captured transfer.
   assign bus_err = align_err
                  | (word_idx >= ADDR_WIDTH'(MEM_DEPTH))
                  | (pprot[1] & (word_idx < ADDR_WIDTH'(SECURE_WORDS)))
                  | (~pwrite & (|pstrb));

   // A read with no wait states is looked up with the live bus address. A
   // read that waits is looked up with the captured index.
   assign rd_idx = (state_reg == ST_IDLE) ? word_idx[IDX_W-1:0] : idx_reg;
   assign mem_we = (state_reg == ST_DONE) & access & write_reg & ~err_reg;

   // The only pprot bit used is bit 1, the secure/non-secure flag.
   assign unused_ok = ^{pprot[2], pprot[0]};

   // The memory is split into byte lanes, so a strobed write needs no read-modify-write.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES; gi++) begin : g_lane
         logic [7:0] lane_mem [MEM_DEPTH];
`ifdef APB_MEM_INIT_EN
         always_ff @(posedge pclk or negedge preset_n) begin
            if (!preset_n) begin
               for (int i = 0; i < MEM_DEPTH; i++) begin
                  lane_mem[i] <= 8'(i >> (8 * gi));
               end
            end else if (mem_we && strb_reg[gi]) begin
               lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
            end
         end
`else
         always_ff @(posedge pclk) begin
            if (mem_we && strb_reg[gi]) begin
               lane_mem[idx_reg] <= wdata_reg[8*gi +: 8];
            end
         end
`endif
         assign rd_word[8*gi +: 8] = lane_mem[rd_idx];
      end
   endgenerate

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         idx_reg   <= '0;
         write_reg <= 1'b0;
         err_reg   <= 1'b0;
         wdata_reg <= '0;
         strb_reg  <= '0;
         prdata    <= '0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               pready  <= 1'b0;
               pslverr <= 1'b0;
               if (setup) begin
                  idx_reg   <= word_idx[IDX_W-1:0];
                  write_reg <= pwrite;
                  err_reg   <= bus_err;
                  wdata_reg <= pwdata;
                  strb_reg  <= pstrb;
                  if (!bus_err && WAIT_CYCLES > 0) begin
                     state_reg <= ST_WAIT;
                     cnt_reg   <= 4'(WAIT_CYCLES);
                  end else begin
                     // A transfer with no wait states, or an error, completes in the first ACCESS cycle.
                     state_reg <= ST_DONE;
                     pready    <= 1'b1;
                     pslverr   <= bus_err;
                     if (bus_err) begin
                        prdata <= '0;
                     end else if (!pwrite) begin
                        prdata <= rd_word;
                     end
                  end
               end
            end
            ST_WAIT: begin
               if (!psel) begin
                  // The master abandoned the transfer, so it is dropped.
                  state_reg <= ST_IDLE;
                  cnt_reg   <= 4'd0;
               end else if (penable) begin
                  if (cnt_reg == 4'd1) begin
                     state_reg <= ST_DONE;
                     cnt_reg   <= 4'd0;
                     pready    <= 1'b1;
                     pslverr   <= 1'b0;
                     if (!write_reg) begin
                        prdata <= rd_word;
                     end
                  end else begin
                     cnt_reg <= cnt_reg - 4'd1;
                  end
               end
            end
            ST_DONE: begin
               // pready is high for exactly one cycle. The write lands only
               // if psel&penable still hold (see mem_we).
               state_reg <= ST_IDLE;
               pready    <= 1'b0;
               pslverr   <= 1'b0;
            end
            default: begin
               state_reg <= ST_IDLE;
               pready    <= 1'b0;
               pslverr   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_completer_v2.sv
// Testbench for apb_mem_completer_v2. It runs two instances: instance 0 has
// WAIT_CYCLES=0 and instance 1 has WAIT_CYCLES=3. A behavioural model holds
// memory contents per byte, each with a known flag. Each transfer's expected
// latency, error and read data come from the address, strobe and protection
// rules. One monitor compares the DUT outputs against these expectations on
// every falling clock edge.
module tb_apb_mem_completer_v2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]        rst_n, psel, penable, pwrite, pready, pslverr;
   logic [1:0][31:0]  paddr, pwdata, prdata;
   logic [1:0][3:0]   pstrb;
   logic [1:0][2:0]   pprot;

   apb_mem_completer_v2 #(.WAIT_CYCLES(0)) dut0 (
      .pclk(clk), .preset_n(rst_n[0]), .psel(psel[0]), .penable(penable[0]),
      .pwrite(pwrite[0]), .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]),
      .pprot(pprot[0]), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

   apb_mem_completer_v2 #(.WAIT_CYCLES(3)) dut1 (
      .pclk(clk), .preset_n(rst_n[1]), .psel(psel[1]), .penable(penable[1]),
      .pwrite(pwrite[1]), .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]),
      .pprot(pprot[1]), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

   int checks = 0;
   int errors = 0;
   int wait_of [2] = '{0, 3};

   // Behavioural memory model: one value per word, and one known flag per byte.
   logic [31:0] mdata  [2][256];
   logic [3:0]  mknown [2][256];

   // Expectation for the transfer in flight on each instance.
   logic        cur_active  [2] = '{1'b0, 1'b0};
   int          cur_lat     [2];
   logic        cur_err     [2];
   logic        cur_wr      [2];
   logic        cur_rd_known[2];
   logic [31:0] cur_rdata   [2];
   // prdata is expected to hold this value between read completions.
   logic        last_known  [2] = '{1'b1, 1'b1};
   logic [31:0] last_rdata  [2] = '{32'h0, 32'h0};

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, got, exp);
      end
   endfunction

   function automatic void model_reset(input int d);
      for (int i = 0; i < 256; i++) begin
`ifdef APB_MEM_INIT_EN
         mdata[d][i]  = 32'(i);
         mknown[d][i] = 4'hF;
`else
         if (d < 0) mknown[d][i] = 4'h0; // never taken; memory survives reset
`endif
      end
   endfunction

   // Monitor: compares the DUT outputs with the model on every falling edge.
   int acc [2] = '{0, 0};
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n[d]) begin
            acc[d] = 0;
            check($sformatf("d%0d_rst_pready", d), 32'(pready[d]), 32'h0);
            check($sformatf("d%0d_rst_pslverr", d), 32'(pslverr[d]), 32'h0);
            check($sformatf("d%0d_rst_prdata", d), prdata[d], 32'h0);
            last_known[d] = 1'b1;
            last_rdata[d] = 32'h0;
         end else if (psel[d] && penable[d]) begin
            acc[d]++;
            if (cur_active[d]) begin
               logic fin;
               fin = (acc[d] == cur_lat[d]);
               check($sformatf("d%0d_pready_acc%0d", d, acc[d]), 32'(pready[d]), 32'(fin));
               check($sformatf("d%0d_pslverr_acc%0d", d, acc[d]), 32'(pslverr[d]), 32'(fin && cur_err[d]));
               if (fin && cur_err[d]) begin
                  check($sformatf("d%0d_err_prdata", d), prdata[d], 32'h0);
                  last_known[d] = 1'b1;
                  last_rdata[d] = 32'h0;
               end else if (fin && !cur_wr[d]) begin
                  if (cur_rd_known[d]) check($sformatf("d%0d_rd_prdata", d), prdata[d], cur_rdata[d]);
                  last_known[d] = cur_rd_known[d];
                  last_rdata[d] = cur_rdata[d];
               end else if (last_known[d]) begin
                  check($sformatf("d%0d_prdata_hold", d), prdata[d], last_rdata[d]);
               end
            end
         end else begin
            acc[d] = 0;
            if (!psel[d]) begin
               check($sformatf("d%0d_idle_pready", d), 32'(pready[d]), 32'h0);
               check($sformatf("d%0d_idle_pslverr", d), 32'(pslverr[d]), 32'h0);
            end
            if (last_known[d]) check($sformatf("d%0d_idle_prdata", d), prdata[d], last_rdata[d]);
         end
      end
   end

   // Runs one complete transfer and loads the expectation before the setup phase.
   task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input logic [2:0] prot,
                       output logic [31:0] rdata, output logic err_o, output int lat);
      logic [31:0] word;
      logic        err;
      logic        seen;
      int          n;
      word = addr >> 2;
      err  = (addr[1:0] != 2'b00) || (word >= 256) || (prot[1] && word < 128) || (!wr && strb != 4'h0);
      cur_err[d] = err;
      cur_wr[d]  = wr;
      cur_lat[d] = err ? 1 : wait_of[d] + 1;
      cur_rd_known[d] = 1'b0;
      cur_rdata[d]    = 32'h0;
      if (!err && !wr) begin
         cur_rd_known[d] = (mknown[d][word[7:0]] == 4'hF);
         cur_rdata[d]    = mdata[d][word[7:0]];
      end
      @(posedge clk); #1;
      psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr;
      pwdata[d] = data; pstrb[d] = strb; pprot[d] = prot;
      cur_active[d] = 1'b1;
      @(posedge clk); #1;
      penable[d] = 1'b1;
      n = 0; seen = 1'b0; rdata = 32'hx; err_o = 1'bx;
      while (!seen && n < 20) begin
         @(negedge clk);
         n++;
         if (pready[d]) begin
            seen  = 1'b1;
            rdata = prdata[d];
            err_o = pslverr[d];
         end
      end
      if (!seen) check($sformatf("d%0d_pready_timeout", d), 32'(n), 32'(cur_lat[d]));
      lat = n;
      @(posedge clk);
      if (seen && !err && wr) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
               mdata[d][word[7:0]][8*b +: 8] = data[8*b +: 8];
               mknown[d][word[7:0]][b] = 1'b1;
            end
         end
      end
      #1;
      psel[d] = 1'b0; penable[d] = 1'b0;
      cur_active[d] = 1'b0;
      $display("xfer d%0d %s addr=%08h wdata=%08h strb=%h prot=%0d -> lat=%0d pslverr=%0b prdata=%08h",
               d, wr ? "WR" : "RD", addr, data, strb, prot, lat, err_o, rdata);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lt;

   initial begin
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) begin
            mknown[d][i] = 4'h0;
            mdata[d][i]  = 32'h0;
         end
         model_reset(d);
      end
      rst_n = 2'b00; psel = '0; penable = '0; pwrite = '0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 2'b11;

      // Instance 0: basic write/read with no wait states.
      xfer(0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 3'b000, rd, er, lt);
      check("w0_lat", 32'(lt), 32'd1);
      check("w0_err", 32'(er), 32'd0);
      xfer(0, 1'b0, 32'h010, 32'h0, 4'h0, 3'b000, rd, er, lt);
      check("r0_lat", 32'(lt), 32'd1);
      check("r0_data", rd, 32'hDEADBEEF);
      // Partial strobe.
      xfer(0, 1'b1, 32'h200, 32'h11223344, 4'hF, 3'b000, rd, er, lt);
      xfer(0, 1'b1, 32'h200, 32'hAABBCCDD, 4'b0101, 3'b000, rd, er, lt);
      xfer(0, 1'b0, 32'h200, 32'h0, 4'h0, 3'b000, rd, er, lt);
      check("strb_data", rd, 32'h11BB33DD);
      // Protection.
      xfer(0, 1'b1, 32'h004, 32'hCAFEF00D, 4'hF, 3'b000, rd, er, lt);
      xfer(0, 1'b1, 32'h004, 32'h55555555, 4'hF, 3'b010, rd, er, lt);
      check("ns_secure_err", 32'(er), 32'd1);
      xfer(0, 1'b0, 32'h004, 32'h0, 4'h0, 3'b000, rd, er, lt);
      check("ns_mem_kept", rd, 32'hCAFEF00D);
      xfer(0, 1'b1, 32'h200, 32'h01020304, 4'hF, 3'b010, rd, er, lt);
      check("ns_open_err", 32'(er), 32'd0);
      xfer(0, 1'b0, 32'h200, 32'h0, 4'h0, 3'b010, rd, er, lt);
      check("ns_open_data", rd, 32'h01020304);
      xfer(0, 1'b1, 32'h200, 32'h0A0B0C0D, 4'hF, 3'b000, rd, er, lt);
      check("s_open_err", 32'(er), 32'd0);
      // Range and strobe errors.
      xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, 3'b000, rd, er, lt);
      check("range_err", 32'(er), 32'd1);
      xfer(0, 1'b0, 32'h010, 32'h0, 4'h1, 3'b000, rd, er, lt);
      check("rdstrb_err", 32'(er), 32'd1);
      check("rdstrb_prdata", rd, 32'h0);

      // Instance 1: three wait states.
      xfer(1, 1'b1, 32'h204, 32'h600DF00D, 4'hF, 3'b000, rd, er, lt);
      check("w3_wr_lat", 32'(lt), 32'd4);
      xfer(1, 1'b0, 32'h204, 32'h0, 4'h0, 3'b000, rd, er, lt);
      check("w3_rd_lat", 32'(lt), 32'd4);
      check("w3_rd_data", rd, 32'h600DF00D);
      xfer(1, 1'b0, 32'h205, 32'h0, 4'h0, 3'b000, rd, er, lt);
      check("w3_mis_lat", 32'(lt), 32'd1);
      check("w3_mis_err", 32'(er), 32'd1);
      check("w3_mis_prdata", rd, 32'h0);

      // psel dropped during the wait states: the write is discarded.
      xfer(1, 1'b1, 32'h208, 32'h13572468, 4'hF, 3'b000, rd, er, lt);
      @(posedge clk); #1;
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h208;
      pwdata[1] = 32'h99999999; pstrb[1] = 4'hF; pprot[1] = 3'b000;
      @(posedge clk); #1 penable[1] = 1'b1;
      @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
      repeat (2) @(posedge clk);
      xfer(1, 1'b0, 32'h208, 32'h0, 4'h0, 3'b000, rd, er, lt);
      check("abort_mem_kept", rd, 32'h13572468);

      // Reset asserted in the second ACCESS cycle of a waiting write.
      xfer(1, 1'b1, 32'h020, 32'hA5A5A5A5, 4'hF, 3'b000, rd, er, lt);
      @(posedge clk); #1;
      psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'h020;
      pwdata[1] = 32'h12345678; pstrb[1] = 4'hF; pprot[1] = 3'b000;
      @(posedge clk); #1 penable[1] = 1'b1;
      @(posedge clk); #2 rst_n[1] = 1'b0;
      #1;
      check("midrst_pready", 32'(pready[1]), 32'h0);
      check("midrst_pslverr", 32'(pslverr[1]), 32'h0);
      psel[1] = 1'b0; penable[1] = 1'b0;
      model_reset(1);
      @(posedge clk); #1 rst_n[1] = 1'b1;
      xfer(1, 1'b0, 32'h020, 32'h0, 4'h0, 3'b000, rd, er, lt);
`ifdef APB_MEM_INIT_EN
      check("midrst_mem", rd, 32'h00000008);
`else
      check("midrst_mem", rd, 32'hA5A5A5A5);
`endif

      // Randomised traffic on both instances.
      for (int k = 0; k < 240; k++) begin
         int          d;
         int          region;
         logic [31:0] w;
         logic [31:0] a;
         logic        wr;
         logic [3:0]  s;
         d      = k % 2;
         region = $urandom_range(0, 3);
         case (region)
            0, 3:    w = 32'($urandom_range(0, 15));
            1:       w = 32'($urandom_range(120, 135));
            default: w = 32'($urandom_range(248, 263));
         endcase
         a  = w << 2;
         if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
         wr = 1'($urandom_range(0, 1));
         s  = wr ? 4'($urandom) : (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
         xfer(d, wr, a, $urandom, s, 3'($urandom), rd, er, lt);
      end

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
